// File: rtl/field_vec_pkg.sv
// field_vec_pkg: shared opcode/state types and the Crandall modulus helper for the field vector units.
package field_vec_pkg;
  typedef enum logic [1:0] {FV_NEG = 2'b00, FV_ADD = 2'b01, FV_SUB = 2'b10, FV_PASS = 2'b11} fv_mode_e;
  typedef enum logic {FV_IDLE, FV_RUN} fv_state_e;
  function automatic logic [127:0] field_p(input int nbits, input logic [127:0] prime_i);
    return (128'd1 << nbits) - prime_i;
  endfunction
endpackage

// File: rtl/field_addsub_lane.sv
// field_addsub_lane: combinational single-lane GF(2^NBITS - PRIME_I) negate/add/subtract/pass.
module field_addsub_lane
  import field_vec_pkg::*;
#(
  parameter int NBITS = 61,
  parameter longint unsigned PRIME_I = 1
) (
  input  logic [1:0]       mode,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  output logic [NBITS-1:0] c
);
  localparam logic [NBITS:0] P = (NBITS+1)'(field_p(NBITS, 128'(PRIME_I)));
  localparam logic [NBITS:0] I = (NBITS+1)'(PRIME_I);
  fv_mode_e op;
  logic [NBITS:0] neg, sum, sum_r, dif, dif_r;
  always_comb begin
    op = fv_mode_e'(mode);
    // ~a + 1 is 2^k - a, so subtracting i lands on p - a without a wide subtract from p
    neg = (a == '0) ? '0 : {1'b0, ~a} + (NBITS+1)'(1) - I;
    sum = {1'b0, a} + {1'b0, b};
    sum_r = (sum >= P) ? sum - P : sum;
    dif = {1'b0, a} - {1'b0, b};
    dif_r = dif[NBITS] ? dif + P : dif;
    c = op == FV_NEG ? NBITS'(neg) :
        op == FV_ADD ? NBITS'(sum_r) :
        op == FV_SUB ? NBITS'(dif_r) : a;
  end
endmodule

// File: rtl/field_addsub_vec.sv
// field_addsub_vec: NLANES-wide modular add/sub/neg/pass over one time-multiplexed lane datapath.
// Optional input canonicality flags enabled by FIELD_ADDSUB_VEC_ERRCHK_EN.
module field_addsub_vec
  import field_vec_pkg::*;
#(
  parameter int NBITS = 61,
  parameter longint unsigned PRIME_I = 1,
  parameter int NLANES = 4
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      en,
  input  logic [2*NLANES-1:0]       mode,
  input  logic [NBITS*NLANES-1:0]   a,
  input  logic [NBITS*NLANES-1:0]   b,
  output logic                      ready,
  output logic                      ready_pulse,
  output logic [NBITS*NLANES-1:0]   c
`ifdef FIELD_ADDSUB_VEC_ERRCHK_EN
  ,output logic [NLANES-1:0]        err
`endif
);
  localparam int IW = NLANES > 1 ? $clog2(NLANES) : 1;
  fv_state_e state, state_next;
  logic [IW-1:0] idx;
  logic [2*NLANES-1:0] mode_r;
  logic [NBITS*NLANES-1:0] a_r, b_r;
  logic [1:0] lane_mode;
  logic [NBITS-1:0] lane_a, lane_b, lane_c;
  logic last, accept;
  always_comb begin
    lane_mode = '0;
    lane_a = '0;
    lane_b = '0;
    for (int j = 0; j < NLANES; j++)
      if (idx == IW'(j)) begin
        lane_mode = mode_r[2*j +: 2];
        lane_a = a_r[NBITS*j +: NBITS];
        lane_b = b_r[NBITS*j +: NBITS];
      end
    last = idx == IW'(NLANES-1);
    accept = state == FV_IDLE && en;
    state_next = accept ? FV_RUN : (state == FV_RUN && last) ? FV_IDLE : state;
    ready = state == FV_IDLE;
  end
  field_addsub_lane #(.NBITS(NBITS), .PRIME_I(PRIME_I)) u_lane (
    .mode(lane_mode),
    .a(lane_a),
    .b(lane_b),
    .c(lane_c)
  );
  always_ff @(posedge clk) state <= rstb ? FV_IDLE : state_next;
  always_ff @(posedge clk) begin
    if (rstb) begin
      idx <= '0;
      mode_r <= '0;
      a_r <= '0;
      b_r <= '0;
      c <= '0;
      ready_pulse <= 1'b0;
    end else begin
      ready_pulse <= state == FV_RUN && last;
      if (accept) begin
        mode_r <= mode;
        a_r <= a;
        b_r <= b;
        idx <= '0;
      end else if (state == FV_RUN) begin
        idx <= last ? '0 : idx + IW'(1);
        for (int j = 0; j < NLANES; j++)
          if (idx == IW'(j)) c[NBITS*j +: NBITS] <= lane_c;
      end
    end
  end
`ifdef FIELD_ADDSUB_VEC_ERRCHK_EN
  localparam logic [NBITS:0] P = (NBITS+1)'(field_p(NBITS, 128'(PRIME_I)));
  // b only matters for ADD/SUB, whose opcodes are exactly the ones with differing bits
  always_ff @(posedge clk) begin
    if (rstb) err <= '0;
    else if (accept)
      for (int j = 0; j < NLANES; j++)
        err[j] <= ({1'b0, a[NBITS*j +: NBITS]} >= P) ||
                  ((^mode[2*j +: 2]) && ({1'b0, b[NBITS*j +: NBITS]} >= P));
  end
`endif
endmodule
